// File: rtl/mem_bridge_pipe_pkg.sv
// Shared encodings for the CPU-to-bus memory bridge: access selects, bus size
// codes, default segment mask and the outstanding-request record.
package mem_bridge_pipe_pkg;

  localparam logic [2:0] SEL_SB  = 3'b000;
  localparam logic [2:0] SEL_SH  = 3'b001;
  localparam logic [2:0] SEL_LBU = 3'b011;
  localparam logic [2:0] SEL_LB  = 3'b100;
  localparam logic [2:0] SEL_LHU = 3'b101;
  localparam logic [2:0] SEL_LH  = 3'b110;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [31:0] SEG_MASK_DEFAULT = 32'h1fff_ffff;

  typedef struct packed {
    logic       wr;
    logic [2:0] sel;
    logic [1:0] lo;
  } req_ent_t;

  // Stores and loads use different select spaces; anything unlisted is a word.
  function automatic size_e decode_size(input logic wr, input logic [2:0] sel);
    size_e size;
    size = SIZE_WORD;
    if (wr) begin
      if (sel == SEL_SB)      size = SIZE_BYTE;
      else if (sel == SEL_SH) size = SIZE_HALF;
    end else begin
      if (sel == SEL_LBU || sel == SEL_LB)      size = SIZE_BYTE;
      else if (sel == SEL_LHU || sel == SEL_LH) size = SIZE_HALF;
    end
    return size;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order FIFO of outstanding bus requests; DEPTH is a power of two so the
// pointers wrap naturally.
module mem_req_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_bridge_pipe.sv
// Pipelined CPU-to-bus bridge: translates and checks requests, tracks them in
// order, and returns extended load data one cycle after each bus response.
module mem_bridge_pipe
  import mem_bridge_pipe_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] SEG_MASK  = SEG_MASK_DEFAULT,
  parameter int          ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [2:0]        cpu_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_adel,
  output logic              cpu_ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok
);

  localparam logic [ADDR_W-1:0] MASK_W = ADDR_W'(SEG_MASK);
  localparam bit                CHK    = (ALIGN_CHK != 0);

  size_e       size;
  logic        misal;
  logic        addr_err;
  logic [1:0]  lo;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  req_ent_t    push_ent;
  req_ent_t    head;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ld_ext;

  assign size  = decode_size(cpu_wr, cpu_sel);
  assign misal = ((size == SIZE_HALF) && cpu_addr[0]) ||
                 ((size == SIZE_WORD) && (cpu_addr[1:0] != 2'b00));
  assign addr_err = CHK && misal;

  // Without alignment checking, misaligned low bits are simply dropped.
  always_comb begin
    lo = cpu_addr[1:0];
    if (size == SIZE_HALF)      lo[0] = 1'b0;
    else if (size == SIZE_WORD) lo    = 2'b00;
  end

  assign data_req    = !rst && cpu_req && !fifo_full && !addr_err;
  assign cpu_addr_ok = data_req && data_addr_ok;
  assign cpu_adel    = !rst && cpu_req && addr_err && !cpu_wr;
  assign cpu_ades    = !rst && cpu_req && addr_err && cpu_wr;
  assign data_wr     = !rst && cpu_wr;
  assign data_size   = rst ? 2'b00 : size;
  assign data_addr   = {cpu_addr[ADDR_W-1:2] & MASK_W[ADDR_W-1:2], 2'b00};

  always_comb begin
    data_wdata = cpu_wdata;
    data_wstrb = 4'b0000;
    case (size)
      SIZE_BYTE: data_wdata = {4{cpu_wdata[7:0]}};
      SIZE_HALF: data_wdata = {2{cpu_wdata[15:0]}};
      default:   data_wdata = cpu_wdata;
    endcase
    if (cpu_wr) begin
      case (size)
        SIZE_BYTE: data_wstrb = 4'b0001 << lo;
        SIZE_HALF: data_wstrb = lo[1] ? 4'b1100 : 4'b0011;
        default:   data_wstrb = 4'b1111;
      endcase
    end
  end

  assign push_ent = '{wr: cpu_wr, sel: cpu_sel, lo: lo};
  assign pop      = data_data_ok && !fifo_empty;

  mem_req_fifo #(
    .W     ($bits(req_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_addr_ok),
    .wdata (push_ent),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    case (head.lo)
      2'd0:    byte_lane = data_rdata[7:0];
      2'd1:    byte_lane = data_rdata[15:8];
      2'd2:    byte_lane = data_rdata[23:16];
      default: byte_lane = data_rdata[31:24];
    endcase
    half_lane = head.lo[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (head.sel)
      SEL_LBU: ld_ext = {24'b0, byte_lane};
      SEL_LB:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
      SEL_LHU: ld_ext = {16'b0, half_lane};
      SEL_LH:  ld_ext = {{16{half_lane[15]}}, half_lane};
      default: ld_ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_ok <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_data_ok <= pop;
      if (pop && !head.wr) cpu_rdata <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_bridge_pipe.sv
// Directed bench for mem_bridge_pipe: bus side driven here, completions
// checked against a queue of expected cpu_rdata values.
module tb_mem_bridge_pipe;
  import mem_bridge_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [2:0]  cpu_sel = 3'b000;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        cpu_adel;
  logic        cpu_ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        data_data_ok = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] SEL_LW = 3'b010;
  localparam logic [2:0] SEL_SW = 3'b111;

  always #5 clk = ~clk;

  mem_bridge_pipe #(
    .ADDR_W    (32),
    .DEPTH     (2),
    .SEG_MASK  (SEG_MASK_DEFAULT),
    .ALIGN_CHK (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_wr       (cpu_wr),
    .cpu_sel      (cpu_sel),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_addr_ok  (cpu_addr_ok),
    .cpu_data_ok  (cpu_data_ok),
    .cpu_rdata    (cpu_rdata),
    .cpu_adel     (cpu_adel),
    .cpu_ades     (cpu_ades),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every cpu_data_ok must match the oldest expectation.
  always @(negedge clk) begin
    if (cpu_data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: got cpu_data_ok=1 expected none pending at %0t", $time);
      end else begin
        chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic wr, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_sel   = sel;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // Entered just after a posedge with the request driven and settled.
  task automatic accept();
    int n = 0;
    while (cpu_addr_ok !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept", {31'b0, cpu_addr_ok}, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    drive(wr, sel, addr, wdata);
    #1;
    accept();
  endtask

  task automatic bus_resp(input logic [31:0] rd, input logic [31:0] exp);
    data_data_ok = 1'b1;
    data_rdata   = rd;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a misaligned load pending: combinational outputs stay quiet.
    drive(1'b0, SEL_LW, 32'h0000_0001, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data_req", {31'b0, data_req}, 32'd0);
    chk("rst_adel", {31'b0, cpu_adel}, 32'd0);
    chk("rst_addr_ok", {31'b0, cpu_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    data_addr_ok = 1'b1;

    // Store byte through the segment mask
    drive(1'b1, SEL_SB, 32'hA000_0003, 32'h0000_0012);
    #1;
    chk("sb_data_req", {31'b0, data_req}, 32'd1);
    chk("sb_addr", data_addr, 32'h0000_0000);
    chk("sb_wstrb", {28'b0, data_wstrb}, 32'h8);
    chk("sb_wdata", data_wdata, 32'h1212_1212);
    chk("sb_size", {30'b0, data_size}, 32'd0);
    chk("sb_wr", {31'b0, data_wr}, 32'd1);
    accept();
    bus_resp(32'hFFFF_FFFF, 32'h0);

    drive(1'b1, SEL_SH, 32'h0000_0012, 32'h0000_ABCD);
    #1;
    chk("sh_addr", data_addr, 32'h0000_0010);
    chk("sh_wstrb", {28'b0, data_wstrb}, 32'hC);
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_size", {30'b0, data_size}, 32'd1);
    accept();
    bus_resp(32'h0, 32'h0);

    drive(1'b1, SEL_SW, 32'hC000_0100, 32'hDEAD_BEEF);
    #1;
    chk("sw_addr", data_addr, 32'h0000_0100);
    chk("sw_wstrb", {28'b0, data_wstrb}, 32'hF);
    chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
    chk("sw_size", {30'b0, data_size}, 32'd2);
    accept();
    bus_resp(32'h0, 32'h0);

    // Loads of every flavour
    drive(1'b0, SEL_LB, 32'h8000_0102, 32'h0);
    #1;
    chk("lb_addr", data_addr, 32'h0000_0100);
    chk("lb_wstrb", {28'b0, data_wstrb}, 32'h0);
    chk("lb_wr", {31'b0, data_wr}, 32'd0);
    chk("lb_size", {30'b0, data_size}, 32'd0);
    accept();
    bus_resp(32'h0080_0000, 32'hFFFF_FF80);
    issue(1'b0, SEL_LBU, 32'h0000_0201, 32'h0);
    bus_resp(32'h0000_F500, 32'h0000_00F5);
    issue(1'b0, SEL_LH, 32'h0000_0302, 32'h0);
    bus_resp(32'h8001_0000, 32'hFFFF_8001);
    issue(1'b0, SEL_LHU, 32'h0000_0300, 32'h0);
    bus_resp(32'h1234_9ABC, 32'h0000_9ABC);
    issue(1'b0, SEL_LW, 32'h0000_0400, 32'h0);
    bus_resp(32'hCAFE_F00D, 32'hCAFE_F00D);
    // A store completion leaves the last load data in place
    issue(1'b1, SEL_SW, 32'h0000_0404, 32'h1111_2222);
    bus_resp(32'h5555_5555, 32'hCAFE_F00D);

    // Misaligned accesses raise exceptions and never reach the bus
    drive(1'b0, SEL_LH, 32'h0000_1001, 32'h0);
    #1;
    chk("mis_adel", {31'b0, cpu_adel}, 32'd1);
    chk("mis_ades_ld", {31'b0, cpu_ades}, 32'd0);
    chk("mis_ld_req", {31'b0, data_req}, 32'd0);
    chk("mis_ld_ok", {31'b0, cpu_addr_ok}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, SEL_SW, 32'h0000_1002, 32'h0);
    #1;
    chk("mis_ades", {31'b0, cpu_ades}, 32'd1);
    chk("mis_adel_st", {31'b0, cpu_adel}, 32'd0);
    chk("mis_st_req", {31'b0, data_req}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Fill to DEPTH: the third request waits; a pop frees it one cycle later
    issue(1'b0, SEL_LW, 32'h0000_0500, 32'h0);
    issue(1'b0, SEL_LW, 32'h0000_0504, 32'h0);
    drive(1'b0, SEL_LW, 32'h0000_0508, 32'h0);
    #1;
    chk("full_req", {31'b0, data_req}, 32'd0);
    chk("full_ok", {31'b0, cpu_addr_ok}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_1111;
    exp_q.push_back(32'h1111_1111);
    #1;
    chk("full_no_bypass", {31'b0, data_req}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    chk("resume_req", {31'b0, data_req}, 32'd1);
    chk("resume_ok", {31'b0, cpu_addr_ok}, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    bus_resp(32'h2222_2222, 32'h2222_2222);
    bus_resp(32'h3333_3333, 32'h3333_3333);

    // Back-to-back loads, each accept overlapping the previous response
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b0, SEL_LBU, 32'h0000_0600 + i, 32'h0);
      else cpu_req = 1'b0;
      if (i > 0) begin
        data_data_ok = 1'b1;
        data_rdata   = 32'h0403_0201 + 32'h1010_1010 * (i - 1);
        exp_q.push_back(32'(((i - 1) % 4) + 1 + 16 * (i - 1)));
      end else begin
        data_data_ok = 1'b0;
      end
      #1;
      if (i < 8) chk("b2b_accept", {31'b0, cpu_addr_ok}, 32'd1);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;

    // Response with nothing outstanding is ignored
    bus_resp_empty: begin
      data_data_ok = 1'b1;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      chk("empty_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    end

    // Reset with two outstanding: their late responses are dropped
    issue(1'b0, SEL_LW, 32'h0000_0700, 32'h0);
    issue(1'b0, SEL_LW, 32'h0000_0704, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdata", cpu_rdata, 32'h0);
    for (int k = 0; k < 2; k++) begin
      data_data_ok = 1'b1;
      data_rdata   = 32'hDEAD_0000 + k;
      @(posedge clk); #1;
      chk("post_rst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    end
    data_data_ok = 1'b0;
    issue(1'b0, SEL_LW, 32'h0000_0708, 32'h0);
    bus_resp(32'h5A5A_5A5A, 32'h5A5A_5A5A);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
